hpc1_rand_source: RTL and testbench

- Randomness producer for the masked HPC1 multipliers.
- Supplies each multiplier's refresh mask (in_r, NUM_SHARES words) and its cross-term pads (in_p, num_quad(NUM_SHARES) words) from a seeded 128-bit Galois LFSR.
- Uses a valid/ready handshake so every random word is delivered exactly once.
- Sits between the top-level seed port and the S-box multiplier instances.

---
 rtl/hpc1_rand_source.sv | 110 +++++++++++
 tb/tb_hpc1_rand_source.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hpc1_rand_source.sv
// hpc1_rand_source: seeded 128-bit Galois LFSR supplying refresh masks and pads to HPC1 multipliers.
// Define HPC1_RAND_FREE_RUN_EN to advance the LFSR every RUN cycle regardless of consumer handshakes.
module hpc1_rand_source #(
  parameter int NUM_SHARES    = 2,
  parameter int BIT_WIDTH     = 1,
  parameter int WARMUP_CYCLES = 16
) (
  input  logic                                                in_clock,
  input  logic                                                in_reset,
  input  logic [31:0]                                         in_seed,
  input  logic                                                in_seed_valid,
  output logic                                                out_seed_ready,
  output logic [NUM_SHARES*BIT_WIDTH-1:0]                     out_r,
  output logic [NUM_SHARES*(NUM_SHARES-1)/2*BIT_WIDTH-1:0]    out_p,
  output logic                                                out_valid,
  input  logic                                                in_ready
);
  function automatic int num_quad(input int n);
    return n * (n - 1) / 2;
  endfunction
  localparam int OW = (NUM_SHARES + num_quad(NUM_SHARES)) * BIT_WIDTH;
  localparam logic [127:0] TAPS = {8'hE1, 120'h0};
`ifdef HPC1_RAND_FREE_RUN_EN
  localparam bit FREE = 1'b1;
`else
  localparam bit FREE = 1'b0;
`endif
  if (OW > 128) begin : g_ow_chk
    $error("hpc1_rand_source: output width exceeds LFSR width");
  end
  if (NUM_SHARES < 2 || WARMUP_CYCLES < 0 || WARMUP_CYCLES > 255) begin : g_par_chk
    $error("hpc1_rand_source: parameter out of range");
  end
  typedef enum logic [1:0] {IDLE, LOAD, WARMUP, RUN} state_t;
  function automatic logic [127:0] advance(input logic [127:0] v);
    logic [127:0] t;
    t = v;
    for (int i = 0; i < OW; i++) t = (t >> 1) ^ (t[0] ? TAPS : 128'd0);
    return t;
  endfunction
  state_t       state;
  logic [127:0] s, s_word, s_load, s_adv;
  logic [1:0]   wcnt, wsel;
  logic [7:0]   wu;
  logic         beat, hs;
  assign beat = in_seed_valid & out_seed_ready;
  assign hs   = out_valid & in_ready;
  assign {out_p, out_r} = out_valid ? s[OW-1:0] : '0;
  always_comb begin
    wsel   = state == LOAD ? wcnt : 2'd0;
    s_word = s;
    s_word[32*wsel +: 32] = in_seed;
    // an all-zero state would lock the LFSR, so the final word forces a nonzero seed
    s_load = (wsel == 2'd3 && s_word == '0) ? 128'd1 : s_word;
    s_adv  = advance(s);
  end
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state          <= IDLE;
      s              <= '0;
      wcnt           <= '0;
      wu             <= '0;
      out_valid      <= 1'b0;
      out_seed_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_seed_ready <= 1'b1;
          if (beat) begin
            s     <= s_load;
            wcnt  <= 2'd1;
            state <= LOAD;
          end
        end
        LOAD: if (beat) begin
          s    <= s_load;
          wcnt <= wcnt + 2'd1;
          if (wcnt == 2'd3) begin
            if (WARMUP_CYCLES == 0) begin
              state     <= RUN;
              out_valid <= 1'b1;
            end else begin
              state          <= WARMUP;
              out_seed_ready <= 1'b0;
              wu             <= 8'(WARMUP_CYCLES);
            end
          end
        end
        WARMUP: begin
          s  <= s_adv;
          wu <= wu - 8'd1;
          if (wu <= 8'd1) begin
            state          <= RUN;
            out_valid      <= 1'b1;
            out_seed_ready <= 1'b1;
          end
        end
        RUN: begin
          // a reseed beat wins over a simultaneous consumer handshake
          if (beat) begin
            s         <= s_load;
            wcnt      <= 2'd1;
            state     <= LOAD;
            out_valid <= 1'b0;
          end else if (FREE || hs) s <= s_adv;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_hpc1_rand_source.sv
// tb_hpc1_rand_source: directed scoreboard bench for hpc1_rand_source (2 shares, 1-bit, warmup 0 and 16).
module tb_hpc1_rand_source;
  localparam logic [127:0] TAPS = {8'hE1, 120'h0};
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;
  logic [31:0] seed0, seed16;
  logic sv0, sv16, rdy0, rdy16, sr0, sr16, v0, v16;
  logic [1:0] r0, r16;
  logic [0:0] p0, p16;
  int checks = 0, errors = 0;
  logic [2:0] q0[$], q16[$];
  logic [127:0] m, m0;
  logic [31:0] sd[4] = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEBABE, 32'h0BADF00D};
  logic [2:0] cur;
  int lat;

  hpc1_rand_source #(.NUM_SHARES(2), .BIT_WIDTH(1), .WARMUP_CYCLES(0)) dut0 (
    .in_clock(clk), .in_reset(rst_n), .in_seed(seed0), .in_seed_valid(sv0),
    .out_seed_ready(sr0), .out_r(r0), .out_p(p0), .out_valid(v0), .in_ready(rdy0));
  hpc1_rand_source #(.NUM_SHARES(2), .BIT_WIDTH(1), .WARMUP_CYCLES(16)) dut16 (
    .in_clock(clk), .in_reset(rst_n), .in_seed(seed16), .in_seed_valid(sv16),
    .out_seed_ready(sr16), .out_r(r16), .out_p(p16), .out_valid(v16), .in_ready(rdy16));

  function automatic logic [127:0] madv(input logic [127:0] s);
    for (int i = 0; i < 3; i++) s = s[0] ? ((s >> 1) ^ TAPS) : (s >> 1);
    return s;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk)
    if (rst_n === 1'b1 && v0 && rdy0 && !(sv0 && sr0)) begin
      if (q0.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb0_extra got %b want none", {p0, r0});
      end else chk("sb0", {p0, r0}, q0.pop_front());
    end

  always @(negedge clk)
    if (rst_n === 1'b1 && v16 && rdy16 && !(sv16 && sr16)) begin
      if (q16.size() == 0) begin
        checks++; errors++;
        $display("FAIL sb16_extra got %b want none", {p16, r16});
      end else chk("sb16", {p16, r16}, q16.pop_front());
    end

  task automatic seed0_load(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c, input logic [31:0] d);
    logic [31:0] w[4];
    w = '{a, b, c, d};
    sv0 = 1'b1;
    foreach (w[i]) begin
      seed0 = w[i];
      @(posedge clk); #1;
    end
    sv0 = 1'b0;
  endtask

  task automatic run0(input int n);
    for (int i = 0; i < n; i++) begin
      q0.push_back(m[2:0]);
      m = madv(m);
    end
    rdy0 = 1'b1;
    repeat (n) @(posedge clk);
    #1 rdy0 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; seed0 = '0; seed16 = '0; sv0 = 0; sv16 = 0; rdy0 = 0; rdy16 = 0;
    #1;
    chk("rst_valid", v0, 0);
    chk("rst_out", {p0, r0}, 0);
    chk("rst_ready", sr0, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("idle_ready", sr0, 1);
    chk("idle_valid", v0, 0);
    // seed 1,0,0,0 with no warmup
    seed0_load(32'h1, 0, 0, 0);
    chk("lat0", v0, 1);
    chk("first_out", {p0, r0}, 3'b001);
    chk("seed_state", dut0.s, 128'h1);
    q0.push_back(3'b001);
    rdy0 = 1'b1;
    @(posedge clk); #1 rdy0 = 1'b0;
    chk("adv_state", dut0.s, {8'h38, 8'h40, 112'h0});
    chk("adv_out", {p0, r0}, 3'b000);
    m = {8'h38, 8'h40, 112'h0};
    run0(6);
    // all-zero seed is forced to 1
    seed0_load(0, 0, 0, 0);
    chk("zero_seed_state", dut0.s, 128'h1);
    chk("zero_seed_out", {p0, r0}, 3'b001);
    m = 128'h1;
    run0(4);
    // stall: outputs hold
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("stall_out", {p0, r0}, m[2:0]);
      chk("stall_valid", v0, 1);
    end
    // full seed, then reseed beat colliding with in_ready
    seed0_load(sd[0], sd[1], sd[2], sd[3]);
    m = {sd[3], sd[2], sd[1], sd[0]};
    m0 = m;
    run0(8);
    rdy0 = 1'b1; sv0 = 1'b1; seed0 = sd[0];
    @(posedge clk); #1;
    rdy0 = 1'b0;
    chk("reseed_drop", v0, 0);
    chk("reseed_noadv", dut0.s[127:32], m[127:32]);
    for (int i = 1; i < 4; i++) begin
      seed0 = sd[i];
      @(posedge clk); #1;
    end
    sv0 = 1'b0;
    chk("reseed_valid", v0, 1);
    m = m0;
    run0(8);
    // warmup 16 with in_ready held
    m = {sd[3], sd[2], sd[1], sd[0]};
    for (int i = 0; i < 16; i++) m = madv(m);
    for (int i = 0; i < 8; i++) begin
      q16.push_back(m[2:0]);
      m = madv(m);
    end
    rdy16 = 1'b1; sv16 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      seed16 = sd[i];
      @(posedge clk); #1;
    end
    sv16 = 1'b0;
    lat = 1;
    while (!v16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("lat16", lat, 17);
    repeat (8) @(posedge clk);
    #1 rdy16 = 1'b0;
    // asynchronous reset in the middle of RUN
    chk("pre_reset_valid", v0, 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("async_valid", v0, 0);
    chk("async_out", {p0, r0}, 0);
    chk("async_ready", sr0, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_reset_ready", sr0, 1);
    chk("post_reset_valid", v0, 0);
    seed0_load(32'h1, 0, 0, 0);
    chk("post_reset_out", {p0, r0}, 3'b001);
    chk("q0_drained", q0.size(), 0);
    chk("q16_drained", q16.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
